// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU-to-Avalon memory bus bridge.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DATA,
        COMMIT,
        HALTED
    } bridge_state_t;

    localparam logic [3:0]  BE_WORD         = 4'hF;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_bus_bridge.sv
// Serialises each CPU instruction into a fetch plus an optional data access on
// one Avalon-MM port, and pulses cpu_clk_enable once per completed instruction.
//
// state  | meaning
// IDLE   | first cycle after reset release
// FETCH  | instruction read on the bus (or halt detect)
// EXEC   | datapath decodes held instruction; data request sampled
// DATA   | load or store on the bus from latched request
// COMMIT | one-cycle commit pulse after a data access
// HALTED | PC hit the halt address; bus quiet until reset
module mem_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] HALT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_instr_address,
    output logic [31:0] cpu_instr_readdata,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_address,
    input  logic [31:0] cpu_data_writedata,
    input  logic [3:0]  cpu_data_byteenable,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clk_enable,
    output logic        active,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    bridge_state_t state;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_be;
    logic          d_read;
    logic          d_write;
    logic          is_halt;
    logic          exec_mem;

    assign is_halt  = (cpu_instr_address == HALT_ADDRESS);
    assign exec_mem = cpu_data_read | cpu_data_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            active             <= 1'b0;
            cpu_instr_readdata <= '0;
            cpu_data_readdata  <= '0;
            d_addr             <= '0;
            d_wdata            <= '0;
            d_be               <= '0;
            d_read             <= 1'b0;
            d_write            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    active <= 1'b1;
                    state  <= FETCH;
                end
                FETCH: begin
                    if (is_halt) begin
                        active <= 1'b0;
                        state  <= HALTED;
                    end else if (!avm_waitrequest) begin
                        cpu_instr_readdata <= avm_readdata;
                        state              <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_mem) begin
                        d_addr  <= cpu_data_address & WORD_ALIGN_MASK;
                        d_wdata <= cpu_data_writedata;
                        d_be    <= cpu_data_byteenable;
                        d_read  <= cpu_data_read;
                        // a load wins when control asserts both; the store is dropped
                        d_write <= cpu_data_write & ~cpu_data_read;
                        state   <= DATA;
                    end else begin
                        state <= FETCH;
                    end
                end
                DATA: begin
                    if (!avm_waitrequest) begin
                        if (d_read) begin
                            cpu_data_readdata <= avm_readdata;
                        end
                        state <= COMMIT;
                    end
                end
                COMMIT: state <= FETCH;
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus outputs decode from state so an async reset drops a strobe at once.
    always_comb begin
        avm_address    = '0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = '0;
        avm_byteenable = '0;
        cpu_clk_enable = 1'b0;
        case (state)
            FETCH: begin
                if (!is_halt) begin
                    avm_read       = 1'b1;
                    avm_address    = cpu_instr_address & WORD_ALIGN_MASK;
                    avm_byteenable = BE_WORD;
                end
            end
            EXEC: cpu_clk_enable = ~exec_mem;
            DATA: begin
                avm_read       = d_read;
                avm_write      = d_write;
                avm_address    = d_addr;
                avm_byteenable = d_be;
                avm_writedata  = d_write ? d_wdata : '0;
            end
            COMMIT: cpu_clk_enable = 1'b1;
            default: ;
        endcase
    end

endmodule
